// File: rtl/aes_pkg.sv
// Shared AES definitions: state type, byte layout constants, round counts
// for each key size, and the per-byte parity helper.
package aes_pkg;

  localparam int BYTE_W  = 8;
  localparam int N_BYTES = 16;
  localparam int STATE_W = BYTE_W * N_BYTES;

  // Byte 0 sits in the top byte lane; byte i occupies
  // [BYTE0_MSB - BYTE_W*i -: BYTE_W] (column-major order).
  localparam int BYTE0_MSB = STATE_W - 1;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef logic [STATE_W-1:0] aes_state_t;

  // Even parity bit per byte. Bit N_BYTES-1 covers byte 0 ([127:120]),
  // bit 0 covers byte 15 ([7:0]).
  function automatic logic [N_BYTES-1:0] byte_parity(input aes_state_t s);
    logic [N_BYTES-1:0] p;
    p = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      p[N_BYTES-1-i] = ^s[BYTE0_MSB - BYTE_W*i -: BYTE_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_ark_stage_if.sv
// Handshake and data bundle of the AddRoundKey stage. The stage itself uses
// the slave modport; the upstream/downstream driver uses master.
// Optional out_parity exists only when AES_ARK_PARITY_EN is defined.
interface aes_ark_stage_if #(
  parameter int RND_W = 4
);
  import aes_pkg::*;

  logic             in_valid;
  logic             in_ready;
  aes_state_t       in_mc_state;
  aes_state_t       in_sr_state;
  logic [RND_W-1:0] in_round;
  logic             in_last;
  aes_state_t       round_key;

  logic             out_valid;
  logic             out_ready;
  aes_state_t       out_state;
  logic [RND_W-1:0] out_round;
  logic             out_last;
  logic             err_round;
`ifdef AES_ARK_PARITY_EN
  logic [N_BYTES-1:0] out_parity;
`endif

  modport master (
    output in_valid, in_mc_state, in_sr_state, in_round, in_last, round_key,
    output out_ready,
    input  in_ready,
    input  out_valid, out_state, out_round, out_last, err_round
`ifdef AES_ARK_PARITY_EN
    , out_parity
`endif
  );

  modport slave (
    input  in_valid, in_mc_state, in_sr_state, in_round, in_last, round_key,
    input  out_ready,
    output in_ready,
    output out_valid, out_state, out_round, out_last, err_round
`ifdef AES_ARK_PARITY_EN
    , out_parity
`endif
  );

endinterface

// File: rtl/aes_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is a plain register so
// the upstream ready path never sees downstream combinational logic.
// States: EMPTY, ONE (main full), TWO (main and skid full). Strict FIFO.
module aes_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_nxt;
  logic              acc;
  logic              pop;
  logic              load_main;
  logic              main_from_skid;
  logic              load_skid;
  logic [DATA_W-1:0] main_p0;
  logic [DATA_W-1:0] skid_p0;

  assign acc       = in_valid & in_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign pop       = out_valid & out_ready;
  assign out_data  = main_p0;

  // Next-state and register load selection.
  always_comb begin
    state_nxt      = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          load_main = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          load_main = 1'b1;
        end else if (acc) begin
          load_skid = 1'b1;
          state_nxt = ST_TWO;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Occupancy state and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
    end
  end

  // Main and skid payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (load_main) main_p0 <= main_from_skid ? skid_p0 : in_data;
      if (load_skid) skid_p0 <= in_data;
    end
  end

endmodule

// File: rtl/aes_ark_stage.sv
// Registered AddRoundKey stage of the pipelined AES round. Selects the
// MixColumns result, or the ShiftRows state on the final round, XORs it with
// the round key and buffers the beat in a 2-entry skid buffer. A sticky
// err_round flags illegal round indices without altering the data.
// Optional feature macro: AES_ARK_PARITY_EN adds per-byte even parity
// (out_parity) stored alongside the state.
module aes_ark_stage
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int RND_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_ark_stage_if.slave    bus
);

`ifdef AES_ARK_PARITY_EN
  localparam int PAR_W = N_BYTES;
`else
  localparam int PAR_W = 0;
`endif
  localparam int PAY_W = STATE_W + RND_W + 1 + PAR_W;

  localparam logic [RND_W-1:0] NR_L = RND_W'(NR);

  logic             acc_p0;
  aes_state_t       sel_p0;
  aes_state_t       xor_p0;
  logic             rnd_bad_p0;
  logic             err_q;
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;

  // ---- stage p0: select, key addition and round check at acceptance ----
  assign acc_p0 = bus.in_valid & bus.in_ready;
  assign sel_p0 = bus.in_last ? bus.in_sr_state : bus.in_mc_state;
  assign xor_p0 = sel_p0 ^ bus.round_key;

  assign rnd_bad_p0 = (bus.in_round == '0)
                    | (bus.in_round > NR_L)
                    | ( bus.in_last & (bus.in_round != NR_L))
                    | (!bus.in_last & (bus.in_round == NR_L));

`ifdef AES_ARK_PARITY_EN
  assign pay_in = {xor_p0, bus.in_round, bus.in_last, byte_parity(xor_p0)};
`else
  assign pay_in = {xor_p0, bus.in_round, bus.in_last};
`endif

  // Sticky round-legality flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (acc_p0 && rnd_bad_p0) begin
      err_q <= 1'b1;
    end
  end

  // ---- stage p1: registered output through the skid buffer ----
  aes_skid_buf #(
    .DATA_W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pay_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_out)
  );

`ifdef AES_ARK_PARITY_EN
  assign {bus.out_state, bus.out_round, bus.out_last, bus.out_parity} = pay_out;
`else
  assign {bus.out_state, bus.out_round, bus.out_last} = pay_out;
`endif

  assign bus.err_round = err_q;

endmodule
